// File: rtl/uart_axi_pkg.sv
// Shared definitions for the UART AXI monitor peripheral and its echo master:
// register offsets, STATUS bit positions, response codes and FSM states.
package uart_axi_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;

    localparam int STATUS_RX_EMPTY = 0;
    localparam int STATUS_RX_FULL  = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST_AR,
        S_ST_R,
        S_GAP,
        S_DT_AR,
        S_DT_R,
        S_WR_AW,
        S_WR_B,
        S_ERROR
    } state_t;

endpackage

// File: rtl/uart_axi_echo_master.sv
// AXI4-Lite initiator that polls the UART peripheral STATUS register, pops each
// received byte, adds ADD_OFFSET and writes it back to the TX side.
module uart_axi_echo_master
    import uart_axi_pkg::*;
#(
    parameter int         C_M_AXI_ADDR_WIDTH = 4,
    parameter int         C_M_AXI_DATA_WIDTH = 32,
    parameter logic [7:0] ADD_OFFSET         = 8'd1,
    parameter int         POLL_GAP           = 16,
    parameter int         TIMEOUT            = 1024
) (
    input  logic                            clk_100MHz,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            clear_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output logic [15:0]                     echo_count,
    output logic [7:0]                      last_byte,
    output logic                            busy,
    output logic                            err
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    state_t           state;
    logic [WD_W-1:0]  wdog;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       tx_byte;

    logic       wd_expired;
    logic [7:0] rx_sum;
    logic       aw_fire, w_fire, aw_done, w_done;
    logic       unused_ok;

    assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));
    assign rx_sum     = M_AXI_RDATA[7:0] + ADD_OFFSET;
    assign aw_fire    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_fire     = M_AXI_WVALID && M_AXI_WREADY;
    // A channel counts as done once it has handshaken, in this cycle or earlier.
    assign aw_done    = aw_fire || !M_AXI_AWVALID;
    assign w_done     = w_fire || !M_AXI_WVALID;
    assign unused_ok  = ^{M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:8], M_AXI_RDATA[STATUS_RX_FULL]};

    assign M_AXI_AWADDR = C_M_AXI_ADDR_WIDTH'(REG_DATA);
    assign M_AXI_WSTRB  = (C_M_AXI_DATA_WIDTH/8)'(1);
    assign busy         = (state != S_IDLE) && (state != S_ERROR);
    assign err          = (state == S_ERROR);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state         <= S_IDLE;
            wdog          <= '0;
            gap_cnt       <= '0;
            tx_byte       <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            echo_count    <= '0;
            last_byte     <= '0;
        end else begin
            wdog <= wdog + WD_W'(1);
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        M_AXI_ARADDR  <= C_M_AXI_ADDR_WIDTH'(REG_STATUS);
                        M_AXI_ARVALID <= 1'b1;
                        state         <= S_ST_AR;
                        wdog          <= '0;
                    end
                end
                S_ST_AR, S_DT_AR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= (state == S_ST_AR) ? S_ST_R : S_DT_R;
                        wdog          <= '0;
                    end else if (wd_expired) begin
                        M_AXI_ARVALID <= 1'b0;
                        state         <= S_ERROR;
                        wdog          <= '0;
                    end
                end
                S_ST_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        wdog         <= '0;
                        if (M_AXI_RRESP != RESP_OKAY) begin
                            state <= S_ERROR;
                        end else if (M_AXI_RDATA[STATUS_RX_EMPTY]) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            M_AXI_ARADDR  <= C_M_AXI_ADDR_WIDTH'(REG_DATA);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_DT_AR;
                        end
                    end else if (wd_expired) begin
                        M_AXI_RREADY <= 1'b0;
                        state        <= S_ERROR;
                        wdog         <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                        state <= S_IDLE;
                        wdog  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                // Once DATA has been read the byte is committed: enable is not
                // consulted again until the write response returns.
                S_DT_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        wdog         <= '0;
                        if (M_AXI_RRESP != RESP_OKAY) begin
                            state <= S_ERROR;
                        end else begin
                            tx_byte       <= rx_sum;
                            M_AXI_WDATA   <= {{(C_M_AXI_DATA_WIDTH-8){1'b0}}, rx_sum};
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= S_WR_AW;
                        end
                    end else if (wd_expired) begin
                        M_AXI_RREADY <= 1'b0;
                        state        <= S_ERROR;
                        wdog         <= '0;
                    end
                end
                S_WR_AW: begin
                    if (aw_fire) M_AXI_AWVALID <= 1'b0;
                    if (w_fire)  M_AXI_WVALID  <= 1'b0;
                    if (aw_done && w_done) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= S_WR_B;
                        wdog         <= '0;
                    end else if (wd_expired) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b0;
                        state         <= S_ERROR;
                        wdog          <= '0;
                    end
                end
                S_WR_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        wdog         <= '0;
                        if (M_AXI_BRESP != RESP_OKAY) begin
                            state <= S_ERROR;
                        end else begin
                            echo_count <= echo_count + 16'd1;
                            last_byte  <= tx_byte;
                            state      <= S_IDLE;
                        end
                    end else if (wd_expired) begin
                        M_AXI_BREADY <= 1'b0;
                        state        <= S_ERROR;
                        wdog         <= '0;
                    end
                end
                S_ERROR: begin
                    if (clear_err) begin
                        state <= S_IDLE;
                        wdog  <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    wdog  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_axi_echo_master.sv
// Directed bench for uart_axi_echo_master against a small behavioural model of
// the UART AXI peripheral (RX byte queue in, TX byte queue out).
module tb_uart_axi_echo_master;

    logic        clk_100MHz = 1'b0;
    logic        reset, enable, clear_err;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [15:0] echo_count;
    logic [7:0]  last_byte;
    logic        busy, err;

    // slave model controls and state
    logic        ar_ok, aw_ok, w_ok;
    logic [1:0]  data_rresp;
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic        aw_got, w_got;
    logic [7:0]  wbyte;
    int          aw_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int snap;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_axi_echo_master dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .enable        (enable),
        .clear_err     (clear_err),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .echo_count    (echo_count),
        .last_byte     (last_byte),
        .busy          (busy),
        .err           (err)
    );

    assign M_AXI_ARREADY = ar_ok;
    assign M_AXI_AWREADY = aw_ok;
    assign M_AXI_WREADY  = w_ok;

    always @(posedge clk_100MHz) begin
        if (reset) begin
            M_AXI_RVALID <= 1'b0;
            M_AXI_RDATA  <= '0;
            M_AXI_RRESP  <= 2'b00;
            M_AXI_BVALID <= 1'b0;
            M_AXI_BRESP  <= 2'b00;
            aw_got = 1'b0;
            w_got  = 1'b0;
        end else begin
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                M_AXI_RVALID <= 1'b1;
                if (M_AXI_ARADDR == 4'h4) begin
                    M_AXI_RDATA <= {30'b0, rxq.size() >= 16, rxq.size() == 0};
                    M_AXI_RRESP <= 2'b00;
                end else begin
                    if (rxq.size() > 0) M_AXI_RDATA <= {24'h0, rxq.pop_front()};
                    else M_AXI_RDATA <= '0;
                    M_AXI_RRESP <= data_rresp;
                end
            end
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_got = 1'b1;
                aw_cnt++;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_got = 1'b1;
                wbyte = M_AXI_WDATA[7:0];
            end
            if (aw_got && w_got) begin
                txq.push_back(wbyte);
                M_AXI_BVALID <= 1'b1;
                M_AXI_BRESP  <= 2'b00;
                aw_got = 1'b0;
                w_got  = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear_err = 1'b0;
        ar_ok = 1'b1; aw_ok = 1'b1; w_ok = 1'b1; data_rresp = 2'b00;
        aw_cnt = 0; aw_got = 1'b0; w_got = 1'b0; wbyte = '0;
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;
        @(negedge clk_100MHz);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_awvalid", M_AXI_AWVALID, 0);
        check("rst_wvalid", M_AXI_WVALID, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_bready", M_AXI_BREADY, 0);
        check("rst_araddr", M_AXI_ARADDR, 0);
        check("rst_wdata", M_AXI_WDATA, 0);
        check("rst_count", echo_count, 0);
        check("rst_last", last_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("wstrb", M_AXI_WSTRB, 4'b0001);

        // 0x41 -> 0x42
        rxq.push_back(8'h41);
        enable = 1'b1;
        @(negedge clk_100MHz);
        check("poll_arvalid", M_AXI_ARVALID, 1);
        check("poll_araddr", M_AXI_ARADDR, 4'h4);
        check("poll_busy", busy, 1);
        for (int i = 0; i < 200 && echo_count !== 16'd1; i++) @(negedge clk_100MHz);
        check("e1_count", echo_count, 1);
        check("e1_last", last_byte, 8'h42);
        check("e1_txlen", txq.size(), 1);
        check("e1_tx", txq[0], 8'h42);

        // 0xFF wraps to 0x00
        rxq.push_back(8'hFF);
        for (int i = 0; i < 300 && echo_count !== 16'd2; i++) @(negedge clk_100MHz);
        check("e2_count", echo_count, 2);
        check("e2_last", last_byte, 8'h00);
        check("e2_tx", txq[1], 8'h00);

        // full FIFO burst drained in order
        for (int i = 0; i < 16; i++) rxq.push_back(8'(i));
        for (int i = 0; i < 1000 && echo_count !== 16'd18; i++) @(negedge clk_100MHz);
        check("burst_count", echo_count, 18);
        check("burst_txlen", txq.size(), 18);
        for (int i = 0; i < 16; i++) check("burst_tx", txq[2 + i], i + 1);
        check("burst_last", last_byte, 8'h10);

        // enable low parks in IDLE
        enable = 1'b0;
        for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk_100MHz);
        check("park_busy", busy, 0);
        repeat (50) @(negedge clk_100MHz);
        check("park_arvalid", M_AXI_ARVALID, 0);
        check("park_busy2", busy, 0);

        // ARREADY never comes: watchdog
        ar_ok = 1'b0;
        enable = 1'b1;
        repeat (1010) @(negedge clk_100MHz);
        check("wd_early_err", err, 0);
        check("wd_early_arvalid", M_AXI_ARVALID, 1);
        for (int i = 0; i < 60 && err !== 1'b1; i++) @(negedge clk_100MHz);
        check("wd_err", err, 1);
        check("wd_arvalid", M_AXI_ARVALID, 0);
        check("wd_busy", busy, 0);
        repeat (5) @(negedge clk_100MHz);
        check("wd_hold", err, 1);
        ar_ok = 1'b1;
        clear_err = 1'b1;
        @(negedge clk_100MHz);
        clear_err = 1'b0;
        check("clr_err", err, 0);
        rxq.push_back(8'h10);
        for (int i = 0; i < 300 && echo_count !== 16'd19; i++) @(negedge clk_100MHz);
        check("resume_count", echo_count, 19);
        check("resume_last", last_byte, 8'h11);

        // SLVERR on DATA read: no write issued
        snap = aw_cnt;
        data_rresp = 2'b10;
        rxq.push_back(8'h20);
        for (int i = 0; i < 300 && err !== 1'b1; i++) @(negedge clk_100MHz);
        check("rerr_err", err, 1);
        repeat (3) @(negedge clk_100MHz);
        check("rerr_awcnt", aw_cnt, snap);
        check("rerr_awvalid", M_AXI_AWVALID, 0);
        check("rerr_count", echo_count, 19);
        check("rerr_txlen", txq.size(), 19);
        data_rresp = 2'b00;
        clear_err = 1'b1;
        @(negedge clk_100MHz);
        clear_err = 1'b0;

        // reset while AWVALID is held
        aw_ok = 1'b0;
        rxq.push_back(8'h30);
        for (int i = 0; i < 300 && M_AXI_AWVALID !== 1'b1; i++) @(negedge clk_100MHz);
        check("aw_stall", M_AXI_AWVALID, 1);
        check("aw_wdata", M_AXI_WDATA, 32'h31);
        @(negedge clk_100MHz);
        check("w_indep_drop", M_AXI_WVALID, 0);
        check("aw_held", M_AXI_AWVALID, 1);
        reset = 1'b1;
        @(negedge clk_100MHz);
        check("mid_rst_awvalid", M_AXI_AWVALID, 0);
        check("mid_rst_wvalid", M_AXI_WVALID, 0);
        check("mid_rst_bready", M_AXI_BREADY, 0);
        check("mid_rst_wdata", M_AXI_WDATA, 0);
        check("mid_rst_count", echo_count, 0);
        check("mid_rst_last", last_byte, 0);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        aw_ok = 1'b1;
        rxq.push_back(8'h7F);
        for (int i = 0; i < 300 && echo_count !== 16'd1; i++) @(negedge clk_100MHz);
        check("restart_count", echo_count, 1);
        check("restart_last", last_byte, 8'h80);
        check("restart_tx", txq[txq.size() - 1], 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
